// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. Each digit slot is BLANK_CYCLES of dark time followed by
// DIG_CYCLES of lit time. Digit k shows hex nibble k of the active display
// word. New data is held in a pending buffer and only becomes active at a
// frame boundary, or straight away while the scanner is idle.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   run         in   1 = scan, 0 = display dark
//   data_vld    in   new display data offered
//   data_rdy    out  controller can accept data (= no data pending)
//   data_in     in   [31:0] hex digits, nibble k drives digit k
//   dp_in       in   [7:0]  decimal points, bit k lights dp of digit k
//   mask_in     in   [7:0]  digit enables, bit k = 0 keeps digit k dark
//   sel_en      out  digit decoder enable
//   sel_add     out  [2:0] digit decoder address
//   seg         out  [7:0] active-low segments, bit7 = dp, bits 6:0 = g..a
//   frame_done  out  one-cycle pulse after digit 7's lit window ends
//
// Handshake: a transfer happens on every rising edge where data_vld and
// data_rdy are both 1. data_rdy is a registered copy of "no data pending";
// data_vld while data_rdy = 0 is ignored, and the offering side does not
// need to hold data_vld for any minimum time.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int DIG_CYCLES   = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        run,
   input  logic        data_vld,
   output logic        data_rdy,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  mask_in,
   output logic        sel_en,
   output logic [2:0]  sel_add,
   output logic [7:0]  seg,
   output logic        frame_done
);

   localparam int MAX_CYCLES = (DIG_CYCLES > BLANK_CYCLES) ? DIG_CYCLES : BLANK_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(DIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_digit;

   logic             r_pend;
   logic             r_rdy;
   logic [31:0]      r_pend_data;
   logic [7:0]       r_pend_dp;
   logic [7:0]       r_pend_mask;
   logic [31:0]      r_act_data;
   logic [7:0]       r_act_dp;
   logic [7:0]       r_act_mask;

   logic             r_sel_en;
   logic [2:0]       r_sel_add;
   logic [7:0]       r_seg;
   logic             r_frame_done;

   logic             w_capture;
   logic             w_commit;
   logic [31:0]      w_act_data;
   logic [7:0]       w_act_dp;
   logic [7:0]       w_act_mask;
   logic [2:0]       w_next_digit;
   logic [3:0]       w_nibble;
   logic [7:0]       w_show_seg;

   // Active-low seven-segment font; the dp bit is cleared when dp is lit.
   function automatic logic [7:0] encode(input logic [3:0] nib, input logic dp);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return {~dp, s};
   endfunction

   always_comb begin
      w_capture    = data_vld & r_rdy;
      // The commit decision looks at r_pend before this edge's capture, so
      // data captured during the frame_done cycle waits for the next frame.
      w_commit     = r_pend & ((r_state == ST_IDLE) | r_frame_done);
      // Look-ahead of the active buffer so a digit entering SHOW on the same
      // edge as a commit already shows the new data.
      w_act_data   = w_commit ? r_pend_data : r_act_data;
      w_act_dp     = w_commit ? r_pend_dp   : r_act_dp;
      w_act_mask   = w_commit ? r_pend_mask : r_act_mask;
      w_next_digit = r_digit + 3'd1;
      w_nibble     = w_act_data[{r_digit, 2'b00} +: 4];
      w_show_seg   = w_act_mask[r_digit] ? encode(w_nibble, w_act_dp[r_digit]) : 8'hFF;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_digit      <= '0;
         r_pend       <= 1'b0;
         r_rdy        <= 1'b1;
         r_pend_data  <= '0;
         r_pend_dp    <= '0;
         r_pend_mask  <= '0;
         r_act_data   <= '0;
         r_act_dp     <= '0;
         r_act_mask   <= '0;
         r_sel_en     <= 1'b0;
         r_sel_add    <= '0;
         r_seg        <= 8'hFF;
         r_frame_done <= 1'b0;
      end else begin
         // Capture and commit are mutually exclusive: capture needs
         // r_pend = 0, commit needs r_pend = 1.
         if (w_capture) begin
            r_pend_data <= data_in;
            r_pend_dp   <= dp_in;
            r_pend_mask <= mask_in;
            r_pend      <= 1'b1;
            r_rdy       <= 1'b0;
         end else if (w_commit) begin
            r_act_data  <= r_pend_data;
            r_act_dp    <= r_pend_dp;
            r_act_mask  <= r_pend_mask;
            r_pend      <= 1'b0;
            r_rdy       <= 1'b1;
         end

         r_frame_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_sel_en  <= 1'b0;
               r_seg     <= 8'hFF;
               r_sel_add <= '0;
               r_cnt     <= '0;
               r_digit   <= '0;
               if (run) begin
                  r_state <= ST_BLANK;
               end
            end

            ST_BLANK: begin
               if (!run) begin
                  r_state   <= ST_IDLE;
                  r_sel_en  <= 1'b0;
                  r_seg     <= 8'hFF;
                  r_sel_add <= '0;
                  r_cnt     <= '0;
                  r_digit   <= '0;
               end else if (r_cnt == BLANK_LAST) begin
                  r_state  <= ST_SHOW;
                  r_cnt    <= '0;
                  r_sel_en <= w_act_mask[r_digit];
                  r_seg    <= w_show_seg;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            ST_SHOW: begin
               if (!run) begin
                  r_state   <= ST_IDLE;
                  r_sel_en  <= 1'b0;
                  r_seg     <= 8'hFF;
                  r_sel_add <= '0;
                  r_cnt     <= '0;
                  r_digit   <= '0;
               end else if (r_cnt == DIG_LAST) begin
                  r_state      <= ST_BLANK;
                  r_cnt        <= '0;
                  r_digit      <= w_next_digit;
                  r_sel_add    <= w_next_digit;
                  r_sel_en     <= 1'b0;
                  r_seg        <= 8'hFF;
                  r_frame_done <= (r_digit == 3'd7);
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign data_rdy   = r_rdy;
   assign sel_en     = r_sel_en;
   assign sel_add    = r_sel_add;
   assign seg        = r_seg;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Bench for seg_scan_ctrl with DIG_CYCLES = 4, BLANK_CYCLES = 2.
// A timeline model (cycles since run started -> frame/digit/phase) predicts
// every output and is compared on each falling edge. A vector table checks
// whole frames for known data words, and hand-written sequences cover
// mid-frame loads, run drop/restart, capture on frame_done and reset.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int DIG   = 4;
   localparam int BLK   = 2;
   localparam int SLOT  = DIG + BLK;
   localparam int FRAME = 8 * SLOT;

   // ---------------- clock / reset / DUT ----------------
   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        run       = 1'b0;
   logic        data_vld  = 1'b0;
   logic [31:0] data_in   = '0;
   logic [7:0]  dp_in     = '0;
   logic [7:0]  mask_in   = '0;
   logic        data_rdy;
   logic        sel_en;
   logic [2:0]  sel_add;
   logic [7:0]  seg;
   logic        frame_done;

   always #5 sys_clk = ~sys_clk;

   seg_scan_ctrl #(
      .DIG_CYCLES   (DIG),
      .BLANK_CYCLES (BLK)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .run        (run),
      .data_vld   (data_vld),
      .data_rdy   (data_rdy),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .mask_in    (mask_in),
      .sel_en     (sel_en),
      .sel_add    (sel_add),
      .seg        (seg),
      .frame_done (frame_done)
   );

   // ---------------- scoreboard counters ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Display font straight from the segment table (dp off).
   logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // m_t = cycles since scanning started (-1 = idle)
   int          m_t    = -1;
   bit          m_fd   = 1'b0;
   bit          m_pend = 1'b0;
   logic [31:0] m_pd   = '0;
   logic [7:0]  m_pdp  = '0;
   logic [7:0]  m_pm   = '0;
   logic [31:0] m_ad   = '0;
   logic [7:0]  m_adp  = '0;
   logic [7:0]  m_am   = '0;
   bit          m_en   = 1'b0;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_t    <= -1;
         m_fd   <= 1'b0;
         m_pend <= 1'b0;
         m_pd   <= '0;
         m_pdp  <= '0;
         m_pm   <= '0;
         m_ad   <= '0;
         m_adp  <= '0;
         m_am   <= '0;
      end else begin
         bit cap;
         bit com;
         int nt;
         cap = data_vld && !m_pend;
         com = m_pend && ((m_t < 0) || m_fd);
         if (cap) begin
            m_pd   <= data_in;
            m_pdp  <= dp_in;
            m_pm   <= mask_in;
            m_pend <= 1'b1;
         end else if (com) begin
            m_ad   <= m_pd;
            m_adp  <= m_pdp;
            m_am   <= m_pm;
            m_pend <= 1'b0;
         end
         if (!run)         nt = -1;
         else if (m_t < 0) nt = 0;
         else              nt = m_t + 1;
         m_t  <= nt;
         m_fd <= (nt > 0) && (nt % FRAME == 0);
      end
   end

   logic       e_en;
   logic [2:0] e_add;
   logic [7:0] e_seg;

   always @(negedge sys_clk) begin
      if (m_en) begin
         int p;
         int d;
         int w;
         e_en  = 1'b0;
         e_add = 3'd0;
         e_seg = 8'hFF;
         if (m_t >= 0) begin
            p     = m_t % FRAME;
            d     = p / SLOT;
            w     = p % SLOT;
            e_add = 3'(d);
            if (w >= BLK && m_am[d]) begin
               e_en  = 1'b1;
               e_seg = font[m_ad[4*d +: 4]];
               if (m_adp[d]) e_seg[7] = 1'b0;
            end
         end
         chk("model_sel_en", 64'(sel_en), 64'(e_en));
         chk("model_sel_add", 64'(sel_add), 64'(e_add));
         chk("model_seg", 64'(seg), 64'(e_seg));
         chk("model_frame_done", 64'(frame_done), 64'(m_fd));
         chk("model_data_rdy", 64'(data_rdy), 64'(!m_pend));
      end
   end

   // ---------------- driver tasks ----------------
   int cur_t = 0;

   task automatic tick();
      @(posedge sys_clk);
      #2;
      cur_t++;
   endtask

   task automatic step_to(input int t);
      while (cur_t < t) tick();
   endtask

   // Offer one word while idle: capture edge, then the idle commit edge.
   task automatic load_idle(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] m);
      data_in  = d;
      dp_in    = dp;
      mask_in  = m;
      data_vld = 1'b1;
      tick();
      data_vld = 1'b0;
      tick();
   endtask

   task automatic start_run();
      run = 1'b1;
      tick();
      cur_t = 0;
   endtask

   task automatic go_idle();
      run = 1'b0;
      tick();
      tick();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [7:0]  mask;
      logic [63:0] exp_seg;  // byte k = expected seg of digit k
      logic [7:0]  exp_en;   // bit k = expected sel_en during digit k SHOW
   } vec_t;

   localparam int NV = 5;
   vec_t vec [NV];

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      vec[0] = '{32'h76543210, 8'h00, 8'hFF, 64'hF8_82_92_99_B0_A4_F9_C0, 8'hFF};
      vec[1] = '{32'hFFFFFFFF, 8'h01, 8'h7E, 64'hFF_8E_8E_8E_8E_8E_8E_FF, 8'h7E};
      vec[2] = '{32'hFFFFFFFF, 8'h01, 8'hFF, 64'h8E_8E_8E_8E_8E_8E_8E_0E, 8'hFF};
      vec[3] = '{32'h89ABCDEF, 8'h00, 8'hFF, 64'h80_90_88_83_C6_A1_86_8E, 8'hFF};
      vec[4] = '{32'hFEDCBA98, 8'h80, 8'hFF, 64'h0E_86_A1_C6_83_88_90_80, 8'hFF};

      // reset state
      repeat (3) @(posedge sys_clk);
      #2;
      chk("rst_sel_en", 64'(sel_en), 64'd0);
      chk("rst_sel_add", 64'(sel_add), 64'd0);
      chk("rst_seg", 64'(seg), 64'hFF);
      chk("rst_data_rdy", 64'(data_rdy), 64'd1);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      sys_rst_n = 1'b1;
      tick();
      m_en = 1'b1;

      // table: one full frame per vector
      for (int i = 0; i < NV; i++) begin
         go_idle();
         load_idle(vec[i].data, vec[i].dp, vec[i].mask);
         start_run();
         for (int t = 0; t < FRAME; t++) begin
            int d;
            d = t / SLOT;
            chk("vec_sel_add", 64'(sel_add), 64'(d));
            if (t % SLOT >= BLK) begin
               chk("vec_sel_en", 64'(sel_en), 64'(vec[i].exp_en[d]));
               chk("vec_seg", 64'(seg), 64'(vec[i].exp_seg[8*d +: 8]));
            end else begin
               chk("vec_blank_en", 64'(sel_en), 64'd0);
               chk("vec_blank_seg", 64'(seg), 64'hFF);
            end
            tick();
         end
         chk("vec_frame_done", 64'(frame_done), 64'd1);
      end

      // mid-frame load: held until frame boundary, second offer ignored
      go_idle();
      load_idle(32'h76543210, 8'h00, 8'hFF);
      start_run();
      step_to(10);
      data_in  = 32'h89ABCDEF;
      dp_in    = 8'h00;
      mask_in  = 8'hFF;
      data_vld = 1'b1;
      tick();
      chk("mid_rdy_low", 64'(data_rdy), 64'd0);
      data_in  = 32'h11111111;
      tick();
      data_vld = 1'b0;
      chk("mid_rdy_hold", 64'(data_rdy), 64'd0);
      step_to(44);
      chk("mid_old_frame_seg", 64'(seg), 64'hF8);
      chk("mid_old_frame_add", 64'(sel_add), 64'd7);
      step_to(48);
      chk("mid_frame_done", 64'(frame_done), 64'd1);
      chk("mid_rdy_at_fd", 64'(data_rdy), 64'd0);
      tick();
      chk("mid_rdy_back", 64'(data_rdy), 64'd1);
      chk("mid_fd_pulse_end", 64'(frame_done), 64'd0);
      step_to(50);
      chk("mid_new_d0", 64'(seg), 64'h8E);
      step_to(56);
      chk("mid_new_d1", 64'(seg), 64'h86);

      // drop run during digit 3 SHOW, then restart
      step_to(FRAME + 3*SLOT + 3);
      run = 1'b0;
      tick();
      chk("drop_seg", 64'(seg), 64'hFF);
      chk("drop_sel_en", 64'(sel_en), 64'd0);
      chk("drop_sel_add", 64'(sel_add), 64'd0);
      chk("drop_fd", 64'(frame_done), 64'd0);
      tick();
      tick();
      chk("drop_still_dark", 64'(seg), 64'hFF);
      start_run();
      chk("restart_blank_en", 64'(sel_en), 64'd0);
      chk("restart_blank_add", 64'(sel_add), 64'd0);
      tick();
      chk("restart_blank_seg", 64'(seg), 64'hFF);
      tick();
      chk("restart_d0_en", 64'(sel_en), 64'd1);
      chk("restart_d0_seg", 64'(seg), 64'h8E);

      // capture in the frame_done cycle: shown in the frame after next
      step_to(FRAME);
      chk("simul_fd", 64'(frame_done), 64'd1);
      chk("simul_rdy", 64'(data_rdy), 64'd1);
      data_in  = 32'h0000000A;
      dp_in    = 8'h00;
      mask_in  = 8'hFF;
      data_vld = 1'b1;
      tick();
      data_vld = 1'b0;
      chk("simul_captured", 64'(data_rdy), 64'd0);
      step_to(FRAME + 2);
      chk("simul_not_yet", 64'(seg), 64'h8E);
      step_to(2*FRAME);
      chk("simul_fd2", 64'(frame_done), 64'd1);
      step_to(2*FRAME + 2);
      chk("simul_committed", 64'(seg), 64'h88);
      chk("simul_rdy_back", 64'(data_rdy), 64'd1);

      // randomized traffic against the model
      run = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) run = ~run;
         data_vld = ($urandom_range(0, 19) == 0);
         data_in  = $urandom;
         dp_in    = 8'($urandom_range(0, 255));
         mask_in  = 8'($urandom_range(0, 255));
         tick();
      end
      data_vld = 1'b0;

      // reset in the middle of a SHOW window with data pending
      go_idle();
      load_idle(32'h76543210, 8'h00, 8'hFF);
      start_run();
      step_to(2);
      chk("prerst_sel_en", 64'(sel_en), 64'd1);
      chk("prerst_seg", 64'(seg), 64'hC0);
      data_in  = 32'h01234567;
      data_vld = 1'b1;
      tick();
      data_vld = 1'b0;
      chk("prerst_pend", 64'(data_rdy), 64'd0);
      sys_rst_n = 1'b0;
      #1;
      chk("midrst_sel_en", 64'(sel_en), 64'd0);
      chk("midrst_seg", 64'(seg), 64'hFF);
      chk("midrst_sel_add", 64'(sel_add), 64'd0);
      chk("midrst_data_rdy", 64'(data_rdy), 64'd1);
      chk("midrst_frame_done", 64'(frame_done), 64'd0);
      run = 1'b0;
      tick();
      tick();
      sys_rst_n = 1'b1;
      tick();
      tick();
      chk("postrst_rdy", 64'(data_rdy), 64'd1);
      chk("postrst_seg", 64'(seg), 64'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
